hinf_frame_sequencer: RTL and testbench

- Frame-level controller for the H-infinity filter core (Hinftop).
- Pops 8-sample EEG frames (64-bit signed fixed-point) from an RX FIFO and replays them to the core with the Start/Xin load protocol.
- Captures the core's 8-word output burst and drains it to a TX FIFO under back-pressure.
- Counts completed frames and flags a core that never answers.

---
 rtl/hinf_frame_sequencer_if.sv | 30 +++
 rtl/hinf_frame_sequencer.sv | 166 ++++++++++++++++
 tb/tb_hinf_frame_sequencer.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hinf_frame_sequencer_if.sv
// Bundle of the three streaming sides of the frame sequencer: the FWFT RX FIFO
// read port, the Start/Xin/D_Wr/D_out port of the filter core and the TX FIFO
// write port.
//   master : the sequencer. It drives rx_rd, core_start, core_xin, tx_wr and tx_data.
//   slave  : the surrounding FIFOs and core. They drive rx_data, rx_empty, core_wr,
//            core_dout and tx_full.
interface hinf_frame_sequencer_if #(
  parameter int unsigned DATA_W = 64
);
  logic              rx_rd;
  logic [DATA_W-1:0] rx_data;
  logic              rx_empty;
  logic              core_start;
  logic [DATA_W-1:0] core_xin;
  logic              core_wr;
  logic [DATA_W-1:0] core_dout;
  logic              tx_full;
  logic              tx_wr;
  logic [DATA_W-1:0] tx_data;

  modport master (
    input  rx_data, rx_empty, core_wr, core_dout, tx_full,
    output rx_rd, core_start, core_xin, tx_wr, tx_data
  );

  modport slave (
    output rx_data, rx_empty, core_wr, core_dout, tx_full,
    input  rx_rd, core_start, core_xin, tx_wr, tx_data
  );
endinterface

// File: rtl/hinf_frame_sequencer.sv
// Frame-level controller for the H-infinity filter core.
// The sequencer pops FRAME_LEN samples from the RX FIFO and replays them to the
// core with the Start/Xin protocol. It captures the core's FRAME_LEN-word output
// burst and drains that burst to the TX FIFO. It counts completed frames and raises
// a sticky flag when the core does not answer within TIMEOUT cycles.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   en           permits a new frame; sampled only while idle
//   err_clr      clears err_timeout and leaves the error state
//   bus          RX/core/TX handshakes (master side of hinf_frame_sequencer_if)
//   busy         high whenever the sequencer is not idle
//   frame_cnt    count of completed frames, wraps modulo 2^CNT_W
//   err_timeout  sticky flag for a core timeout
// FRAME_LEN must be at least 2.
module hinf_frame_sequencer #(
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned FRAME_LEN = 8,
  parameter int unsigned TIMEOUT   = 4096,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  err_clr,
  hinf_frame_sequencer_if.master bus,
  output logic                  busy,
  output logic [CNT_W-1:0]      frame_cnt,
  output logic                  err_timeout
);

  localparam int unsigned IdxW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(FRAME_LEN - 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle, StFetch, StStart, StLoad, StWait, StDrain, StErr
  } state_e;

  state_e            state_q;
  logic [IdxW-1:0]   idx_q;        // fetch / load / capture / drain word index
  logic [IdxW-1:0]   idx_inc;
  logic [TmoW-1:0]   tmo_q;
  logic              capturing_q;  // WAIT has seen core_wr; the burst is in progress
  logic              core_start_q;
  logic [DATA_W-1:0] core_xin_q;
  logic [CNT_W-1:0]  frame_cnt_q;
  logic              err_q;

  logic [DATA_W-1:0] in_buf  [FRAME_LEN];
  logic [DATA_W-1:0] out_buf [FRAME_LEN];

  logic rx_pop;
  logic tx_push;
  logic cap_en;

  assign idx_inc = idx_q + IdxW'(1);
  assign rx_pop  = (state_q == StFetch) & ~bus.rx_empty;
  assign tx_push = (state_q == StDrain) & ~bus.tx_full;
  // While not capturing, idx_q is 0, so the first word of the burst lands in out_buf[0].
  assign cap_en  = (state_q == StWait) & (capturing_q | bus.core_wr);

  // The frame buffers have no reset because their contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (rx_pop) in_buf[idx_q] <= bus.rx_data;
    if (cap_en) out_buf[idx_q] <= bus.core_dout;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      tmo_q        <= '0;
      capturing_q  <= 1'b0;
      core_start_q <= 1'b0;
      core_xin_q   <= '0;
      frame_cnt_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (en) begin
            state_q <= StFetch;
            idx_q   <= '0;
          end
        end
        StFetch: begin
          if (rx_pop) begin
            if (idx_q == IdxLast) begin
              state_q      <= StStart;
              idx_q        <= '0;
              core_start_q <= 1'b1;
              core_xin_q   <= '0;
            end else begin
              idx_q <= idx_inc;
            end
          end
        end
        StStart: begin
          state_q    <= StLoad;
          core_xin_q <= in_buf[0];
        end
        StLoad: begin
          if (idx_q == IdxLast) begin
            state_q      <= StWait;
            idx_q        <= '0;
            tmo_q        <= '0;
            capturing_q  <= 1'b0;
            core_start_q <= 1'b0;
            core_xin_q   <= '0;
          end else begin
            idx_q      <= idx_inc;
            core_xin_q <= in_buf[idx_inc];
          end
        end
        StWait: begin
          if (capturing_q) begin
            if (idx_q == IdxLast) begin
              state_q     <= StDrain;
              idx_q       <= '0;
              capturing_q <= 1'b0;
            end else begin
              idx_q <= idx_inc;
            end
          end else if (bus.core_wr) begin
            capturing_q <= 1'b1;
            idx_q       <= idx_inc;
          end else if (tmo_q == TmoLast) begin
            state_q <= StErr;
            err_q   <= 1'b1;
          end else begin
            tmo_q <= tmo_q + TmoW'(1);
          end
        end
        StDrain: begin
          if (tx_push) begin
            if (idx_q == IdxLast) begin
              state_q     <= StIdle;
              idx_q       <= '0;
              frame_cnt_q <= frame_cnt_q + CNT_W'(1);
            end else begin
              idx_q <= idx_inc;
            end
          end
        end
        StErr: begin
          if (err_clr) begin
            state_q <= StIdle;
            err_q   <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.rx_rd      = rx_pop;
  assign bus.core_start = core_start_q;
  assign bus.core_xin   = core_xin_q;
  assign bus.tx_wr      = tx_push;
  assign bus.tx_data    = (state_q == StDrain) ? out_buf[idx_q] : '0;
  assign busy           = (state_q != StIdle);
  assign frame_cnt      = frame_cnt_q;
  assign err_timeout    = err_q;

endmodule

// File: tb/tb_hinf_frame_sequencer.sv
// Scoreboard bench for hinf_frame_sequencer. The bench has a queue-based RX FIFO, a
// core model that returns twice each input sample, and a TX sink with back-pressure.
// Each issued frame pushes its expected Xin words and TX words into queues. The
// core-side and TX-side monitors pop those queues and compare against the DUT.
module tb_hinf_frame_sequencer;
  localparam int unsigned DataW       = 64;
  localparam int unsigned FrameLen    = 8;
  localparam int unsigned Timeout     = 300;
  localparam int unsigned CntW        = 2;
  localparam int unsigned FrameBudget = Timeout + 800;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            en = 1'b0;
  logic            err_clr = 1'b0;
  logic            busy;
  logic [CntW-1:0] frame_cnt;
  logic            err_timeout;

  hinf_frame_sequencer_if #(.DATA_W(DataW)) bus ();

  hinf_frame_sequencer #(
    .DATA_W   (DataW),
    .FRAME_LEN(FrameLen),
    .TIMEOUT  (Timeout),
    .CNT_W    (CntW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .err_clr    (err_clr),
    .bus        (bus),
    .busy       (busy),
    .frame_cnt  (frame_cnt),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  longint unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference state shared by the stimulus and the monitors
  logic [DataW-1:0] rx_dq[$];
  int unsigned      rx_gq[$];     // empty cycles to show before each word reaches the head
  logic [DataW-1:0] exp_xin_q[$];
  logic [DataW-1:0] exp_tx_q[$];
  logic [CntW-1:0]  exp_cnt = '0;
  bit               core_respond = 1'b1;
  int unsigned      core_lat = 50;
  int               tx_stall_at = -1;
  int unsigned      tx_stall_len = 0;
  bit               tx_rand_bp = 1'b0;
  longint unsigned  wait_entry_cyc = 0;
  int unsigned      start_run = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_word(input logic [DataW-1:0] d, input int unsigned gap, input bit exp_tx);
    rx_dq.push_back(d);
    rx_gq.push_back(gap);
    exp_xin_q.push_back(d);
    if (exp_tx) exp_tx_q.push_back(d << 1);
  endtask

  task automatic push_random_frame(input bit exp_tx, input int unsigned max_gap);
    for (int i = 0; i < FrameLen; i++)
      push_word({$urandom, $urandom}, (max_gap == 0) ? 0 : $urandom_range(0, max_gap), exp_tx);
  endtask

  // Pulses en, then waits (bounded) for the frame to finish or error out.
  task automatic run_frame(input bit exp_err, output int unsigned busy_cyc,
                           output longint unsigned end_cyc);
    int unsigned n;
    bit seen;
    bit done;
    n = 0; seen = 0; done = 0; busy_cyc = 0; end_cyc = 0;
    @(posedge clk); #1;
    en = 1'b1;
    while (!done && n < FrameBudget) begin
      @(negedge clk);
      n++;
      if (busy) begin
        seen = 1'b1;
        en = 1'b0;
      end
      if (seen && (!busy || err_timeout)) begin
        done = 1'b1;
        end_cyc = cyc;
      end else if (busy) begin
        busy_cyc++;
      end
    end
    en = 1'b0;
    check("frame_terminates", done, 1);
    check("err_timeout_state", err_timeout, exp_err);
  endtask

  task automatic frame_done_checks(input string tag);
    check({tag, "_frame_cnt"}, frame_cnt, exp_cnt);
    check({tag, "_xin_consumed"}, exp_xin_q.size(), 0);
    check({tag, "_tx_all_pushed"}, exp_tx_q.size(), 0);
    check({tag, "_busy_low"}, busy, 0);
  endtask

  // RX FIFO: inputs change 1 time unit after posedge; rx_rd is sampled on negedge.
  initial begin : rx_model
    bit pop;
    bus.rx_empty = 1'b1;
    bus.rx_data  = '0;
    forever begin
      @(negedge clk);
      pop = bus.rx_rd && !bus.rx_empty;
      if (bus.rx_rd) check("rx_rd_only_when_nonempty", bus.rx_empty, 0);
      @(posedge clk); #1;
      if (pop && rx_dq.size() != 0) begin
        void'(rx_dq.pop_front());
        void'(rx_gq.pop_front());
      end
      if (rx_dq.size() != 0 && rx_gq[0] != 0) begin
        rx_gq[0] = rx_gq[0] - 1;
        bus.rx_empty = 1'b1;
        bus.rx_data  = '0;
      end else if (rx_dq.size() != 0) begin
        bus.rx_empty = 1'b0;
        bus.rx_data  = rx_dq[0];
      end else begin
        bus.rx_empty = 1'b1;
        bus.rx_data  = '0;
      end
    end
  end

  // Core model: checks the Start/Xin train, then returns 2*x after core_lat cycles.
  initial begin : core_model
    logic [DataW-1:0] rcv [FrameLen];
    int unsigned run;
    int unsigned cnt;
    int unsigned out_idx;
    bit pending;
    run = 0; cnt = 0; out_idx = FrameLen; pending = 0;
    bus.core_wr   = 1'b0;
    bus.core_dout = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        run = 0; pending = 0; out_idx = FrameLen;
      end else if (bus.core_start) begin
        if (run == 0) begin
          check("xin_zero_in_start_cycle", bus.core_xin, 0);
        end else begin
          check("xin_expected_available", exp_xin_q.size() != 0, 1);
          if (exp_xin_q.size() != 0) check("core_xin", bus.core_xin, exp_xin_q.pop_front());
          if (run <= FrameLen) rcv[run-1] = bus.core_xin;
        end
        run++;
      end else if (run != 0) begin
        check("core_start_high_cycles", run, FrameLen + 1);
        wait_entry_cyc = cyc;
        pending = core_respond;
        cnt = core_lat;
        run = 0;
      end
      start_run = run;
      @(posedge clk); #1;
      if (!rst_n) begin
        bus.core_wr = 1'b0;
      end else if (pending) begin
        if (cnt <= 1) begin
          pending = 0;
          bus.core_wr   = 1'b1;
          bus.core_dout = rcv[0] << 1;
          out_idx = 1;
        end else begin
          cnt--;
          bus.core_wr = 1'b0;
        end
      end else if (out_idx < FrameLen) begin
        // core_wr is noise during the burst; the sequencer must ignore it
        bus.core_wr   = 1'($urandom_range(0, 1));
        bus.core_dout = rcv[out_idx] << 1;
        out_idx++;
      end else if (run != 0 && run < FrameLen + 1) begin
        bus.core_wr   = 1'($urandom_range(0, 1));  // spurious D_Wr while loading
        bus.core_dout = {$urandom, $urandom};
      end else begin
        bus.core_wr   = 1'b0;
        bus.core_dout = {$urandom, $urandom};
      end
    end
  end

  // TX sink: scoreboard on every push; optional fixed stall and random back-pressure.
  initial begin : tx_model
    bit pushed;
    int unsigned pushes;
    int unsigned stall_left;
    pushes = 0; stall_left = 0;
    bus.tx_full = 1'b0;
    forever begin
      @(negedge clk);
      pushed = 0;
      if (!rst_n) begin
        pushes = 0;
        stall_left = 0;
      end else if (bus.tx_wr) begin
        check("tx_wr_while_full", bus.tx_full, 0);
        check("tx_expected_available", exp_tx_q.size() != 0, 1);
        if (exp_tx_q.size() != 0) check("tx_data", bus.tx_data, exp_tx_q.pop_front());
        pushed = !bus.tx_full;
      end
      @(posedge clk); #1;
      if (pushed) pushes++;
      if (stall_left != 0) begin
        bus.tx_full = 1'b1;
        stall_left--;
      end else if (pushed && tx_stall_at >= 0 && int'(pushes % FrameLen) == tx_stall_at) begin
        bus.tx_full = 1'b1;
        stall_left = tx_stall_len - 1;
      end else begin
        bus.tx_full = tx_rand_bp && ($urandom_range(0, 3) == 0);
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got time %0t required finish before it", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int unsigned bc;
    longint unsigned ec;
    int unsigned n;
    #1 rst_n = 1'b0;
    #11;
    check("rst_busy", busy, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_err_timeout", err_timeout, 0);
    check("rst_core_start", bus.core_start, 0);
    check("rst_core_xin", bus.core_xin, 0);
    check("rst_rx_rd", bus.rx_rd, 0);
    check("rst_tx_wr", bus.tx_wr, 0);
    check("rst_tx_data", bus.tx_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Nominal: samples 1..8, core answers 50 cycles after Start falls
    for (int i = 1; i <= FrameLen; i++) push_word(DataW'(i), 0, 1'b1);
    repeat (2) @(posedge clk);
    core_lat = 50;
    run_frame(1'b0, bc, ec);
    exp_cnt++;
    frame_done_checks("nominal");
    check("nominal_busy_cycles", bc, 4 * FrameLen + 1 + 50);

    // RX starvation: 20 empty cycles after the third pop
    for (int i = 0; i < FrameLen; i++) push_word({$urandom, $urandom}, (i == 3) ? 20 : 0, 1'b1);
    core_lat = $urandom_range(1, 30);
    run_frame(1'b0, bc, ec);
    exp_cnt++;
    frame_done_checks("starve");

    // TX back-pressure: full for 5 cycles after the fourth push
    push_random_frame(1'b1, 0);
    tx_stall_at = 4;
    tx_stall_len = 5;
    run_frame(1'b0, bc, ec);
    tx_stall_at = -1;
    exp_cnt++;
    frame_done_checks("backpressure");

    // Timeout: the core never answers, so the frame is discarded
    core_respond = 1'b0;
    push_random_frame(1'b0, 0);
    run_frame(1'b1, bc, ec);
    check("timeout_latency", ec - wait_entry_cyc, Timeout);
    check("timeout_frame_cnt_held", frame_cnt, exp_cnt);
    check("timeout_xin_consumed", exp_xin_q.size(), 0);
    core_respond = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("err_held_without_clr", err_timeout, 1);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    @(negedge clk);
    check("err_clr_flag", err_timeout, 0);
    check("err_clr_idle", busy, 0);

    // Two more frames wrap the 2-bit counter: 0 then 1
    for (int f = 0; f < 2; f++) begin
      push_random_frame(1'b1, 2);
      core_lat = $urandom_range(1, 40);
      run_frame(1'b0, bc, ec);
      exp_cnt++;
      frame_done_checks("wrap");
    end
    repeat (10) @(negedge clk);
    check("en_low_stays_idle", busy, 0);
    check("en_low_cnt_held", frame_cnt, exp_cnt);

    // Reset during LOAD at k=3
    push_random_frame(1'b1, 0);
    @(posedge clk); #1;
    en = 1'b1;
    n = 0;
    do begin
      @(negedge clk); #2;
      if (busy) en = 1'b0;
      n++;
    end while (start_run != 5 && n < FrameBudget);
    en = 1'b0;
    check("reached_load_k3", start_run, 5);
    rst_n = 1'b0;
    #1;
    check("async_rst_core_start", bus.core_start, 0);
    check("async_rst_core_xin", bus.core_xin, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_frame_cnt", frame_cnt, 0);
    check("async_rst_rx_rd", bus.rx_rd, 0);
    check("async_rst_tx_wr", bus.tx_wr, 0);
    exp_cnt = '0;
    rx_dq.delete();
    rx_gq.delete();
    exp_xin_q.delete();
    exp_tx_q.delete();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    push_random_frame(1'b1, 0);
    repeat (2) @(posedge clk);
    run_frame(1'b0, bc, ec);
    exp_cnt++;
    frame_done_checks("after_reset");

    // Random frames with RX gaps, TX back-pressure and varied core latency
    tx_rand_bp = 1'b1;
    for (int f = 0; f < 6; f++) begin
      push_random_frame(1'b1, 3);
      core_lat = $urandom_range(1, 60);
      run_frame(1'b0, bc, ec);
      exp_cnt++;
      frame_done_checks("random");
    end
    tx_rand_bp = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
